jtframe_dwnld_router: RTL

Parametrised ROM-download router between `hps_io` ioctl byte stream and the SDRAM programming port (`prog_*`) of `jtframe_board`. Strips a configurable header, maps each byte into one of up to 8 SDRAM regions with per-region relocation, and buffers bytes in a small FIFO while the SDRAM controller is busy. Holds `dwnld_busy` until the last buffered byte is committed, so game reset release waits for SDRAM completion, not for the end of the HPS transfer.

---
 rtl/jtframe_dwnld_router.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/jtframe_dwnld_router.sv
// ROM download router: strips a header from the ioctl byte stream, relocates each byte
// into its SDRAM region and queues it in a small FIFO ahead of the prog_* port.
module jtframe_dwnld_router #(
  parameter int unsigned              REGIONS    = 4,
  parameter logic [22*REGIONS-1:0]    START      = '0,
  parameter logic [22*REGIONS-1:0]    OFFSET     = '0,
  parameter int unsigned              HEADER     = 0,
  parameter bit                       SWAB       = 1'b0,
  parameter int unsigned              FIFO_DEPTH = 4
) (
  input  logic        clk_sys,
  input  logic        rst,
  input  logic        downloading,
  input  logic [21:0] ioctl_addr,
  input  logic [7:0]  ioctl_data,
  input  logic        ioctl_wr,
  output logic [21:0] prog_addr,
  output logic [7:0]  prog_data,
  output logic [1:0]  prog_mask,
  output logic        prog_we,
  input  logic        prog_rdy,
  output logic [2:0]  prog_region,
  output logic        dwnld_busy,
  output logic        overflow,
  output logic        dbg_state_o
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [21:0] HDR = 22'(HEADER);

  typedef struct packed {
    logic [21:0] addr;
    logic [7:0]  data;
    logic [1:0]  mask;
    logic [2:0]  region;
  } entry_t;

  localparam entry_t RST_OUT = '{addr: 22'd0, data: 8'd0, mask: 2'b11, region: 3'd0};

  typedef enum logic {IDLE = 1'b0, PRESENT = 1'b1} state_t;

  // Handshake: prog_we is high while an entry is presented and its outputs stay frozen;
  // the entry is committed in the cycle where prog_we and prog_rdy are both high.
  state_t          state_q, state_d;
  entry_t          out_q, out_d;
  entry_t          mem_q [FIFO_DEPTH];
  entry_t          in_entry;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            dl_q, busy_q, busy_d, ovf_q, ovf_d;

  logic [21:0]     strip_a, base_a, off_a, byte_a;
  logic [2:0]      reg_idx;
  logic            accept, fifo_full, fifo_empty, push, pop, drop, dl_rise;

  // Region lookup relies on START being ascending: the last match is the largest index.
  always_comb begin
    strip_a = ioctl_addr - HDR;
    reg_idx = 3'd0;
    base_a  = 22'd0;
    off_a   = OFFSET[21:0];
    for (int r = 1; r < int'(REGIONS); r++) begin
      if (strip_a >= START[22*r +: 22]) begin
        reg_idx = 3'(r);
        base_a  = START[22*r +: 22];
        off_a   = OFFSET[22*r +: 22];
      end
    end
    byte_a          = strip_a - base_a + off_a;
    in_entry.addr   = {1'b0, byte_a[21:1]};
    in_entry.data   = ioctl_data;
    in_entry.mask   = (byte_a[0] ^ SWAB) ? 2'b01 : 2'b10;
    in_entry.region = reg_idx;
  end

  assign accept     = ioctl_wr && downloading && (ioctl_addr >= HDR);
  assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign pop        = !fifo_empty && ((state_q == IDLE) || prog_rdy);
  // A pop in the same cycle frees the slot, so a full FIFO can still take the byte.
  assign push       = accept && (!fifo_full || pop);
  assign drop       = accept && fifo_full && !pop;
  assign dl_rise    = downloading && !dl_q;

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          state_d = PRESENT;
          out_d   = mem_q[rd_ptr_q];
        end
      end
      PRESENT: begin
        if (prog_rdy) begin
          if (!fifo_empty) out_d = mem_q[rd_ptr_q];
          else             state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_d = busy_q;
    if (dl_rise)
      busy_d = 1'b1;
    else if (!downloading && fifo_empty && (state_q == IDLE))
      busy_d = 1'b0;
    ovf_d = ovf_q;
    if (dl_rise) ovf_d = 1'b0;
    if (drop)    ovf_d = 1'b1;
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state_q  <= IDLE;
      out_q    <= RST_OUT;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dl_q     <= 1'b0;
      busy_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      out_q    <= out_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dl_q     <= downloading;
      busy_q   <= busy_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage needs no reset; the pointers define which entries are live.
  always_ff @(posedge clk_sys) begin
    if (push) mem_q[wr_ptr_q] <= in_entry;
  end

  assign prog_addr   = out_q.addr;
  assign prog_data   = out_q.data;
  assign prog_mask   = out_q.mask;
  assign prog_region = out_q.region;
  assign prog_we     = (state_q == PRESENT);
  assign dwnld_busy  = busy_q;
  assign overflow    = ovf_q;
  assign dbg_state_o = state_q;

endmodule
